param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_if.sv | 49 ++++
 rtl/param_fifo.sv | 133 +++++++++++++
 tb/tb_param_fifo.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/param_fifo_if.sv
// param_fifo_if: bundles the data-path and status signals of param_fifo.
// Latency: none; wires only.
// Backpressure: producer watches full, consumer watches empty. The FIFO
//   ignores a push it cannot accept and a pop it cannot service.
//
// Signals:
//   clear        master->slave  synchronous flush of contents
//   push/indata  master->slave  write request and write data
//   pop          master->slave  read request; consumes the word on outdata
//   outdata      slave->master  oldest stored word (first-word-fall-through)
//   empty, full, almost_full, count   slave->master  occupancy status
//   overflow, underflow   slave->master  sticky error flags
//                         (present only when FIFO_ERR_EN is defined)
interface param_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 11
);
  logic                  clear;
  logic                  push;
  logic [WIDTH-1:0]      indata;
  logic                  pop;
  logic [WIDTH-1:0]      outdata;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic [DEPTH_LOG2:0]   count;
`ifdef FIFO_ERR_EN
  logic                  overflow;
  logic                  underflow;
`endif

  // Producer/consumer side: drives the requests and observes the status.
  modport master (
    output clear, push, indata, pop,
    input  outdata, empty, full, almost_full, count
`ifdef FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  // FIFO side.
  modport slave (
    input  clear, push, indata, pop,
    output outdata, empty, full, almost_full, count
`ifdef FIFO_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/param_fifo.sv
// param_fifo: synchronous first-word-fall-through FIFO of 2**DEPTH_LOG2 words.
// Latency: a word pushed at edge N appears on outdata after edge N.
// Backpressure: a push while full is dropped unless a pop is accepted in the
//   same cycle. A pop while empty is dropped.
//
// Ports:
//   clk   rising-edge clock for all state
//   rstn  synchronous active-low reset; overrides clear, push and pop
//   bus   param_fifo_if.slave: clear, push, indata, pop, outdata, empty,
//         full, almost_full, count (+ overflow, underflow)
// Optional feature: define FIFO_ERR_EN to add the sticky overflow and
//   underflow flags. These flags are cleared only by rstn, not by clear.
module param_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH_LOG2   = 11,
  parameter int AFULL_THRESH = 2**DEPTH_LOG2 - 16
) (
  input  logic         clk,
  input  logic         rstn,
  param_fifo_if.slave  bus
);

  localparam int DEPTH = 2**DEPTH_LOG2;
  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int AW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int CW    = DEPTH_LOG2 + 1;

  // When the pointers differ only in the wrap bit, the FIFO is full.
  localparam logic [PW-1:0] WRAP_ONLY = PW'(1) << DEPTH_LOG2;
  localparam logic [CW-1:0] AF_TH     = CW'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_addr, tail_addr;

  logic empty_w, full_w;
  logic pop_acc, push_acc, wr_en;

  // Storage address = pointer without the wrap bit.
  // A single-entry FIFO always uses address 0.
  generate
    if (DEPTH_LOG2 == 0) begin : g_addr_one
      assign head_addr = '0;
      assign tail_addr = '0;
    end else begin : g_addr_many
      assign head_addr = head_q[DEPTH_LOG2-1:0];
      assign tail_addr = tail_q[DEPTH_LOG2-1:0];
    end
  endgenerate

  assign empty_w = (head_q == tail_q);
  assign full_w  = ((head_q ^ tail_q) == WRAP_ONLY);

  // When the FIFO is full, a pop in the same cycle frees the slot that the
  // simultaneous push needs.
  assign pop_acc  = bus.pop & ~empty_w;
  assign push_acc = bus.push & (~full_w | pop_acc);

  // Clear and reset both discard the write. The array itself is never
  // erased, because the pointers alone define what is valid.
  assign wr_en = rstn & ~bus.clear & push_acc;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_acc)  head_d = head_q + PW'(1);
      if (push_acc) tail_d = tail_q + PW'(1);
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[tail_addr] <= bus.indata;
  end

  assign bus.outdata     = mem[head_addr];
  assign bus.empty       = empty_w;
  assign bus.full        = full_w;
  assign bus.almost_full = (count_q >= AF_TH);
  assign bus.count       = count_q;

`ifdef FIFO_ERR_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // The flags follow the acceptance rules directly, so an error is still
  // recorded in a cycle where clear flushes the FIFO.
  always_comb begin
    ovf_d = ovf_q | (bus.push & ~push_acc);
    unf_d = unf_q | (bus.pop & empty_w);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: checks param_fifo (WIDTH=8, DEPTH_LOG2=2, AFULL_THRESH=3)
// against a queue-based reference model, using directed and random cycles.
module tb_param_fifo;
  localparam int W  = 8;
  localparam int DL = 2;
  localparam int D  = 4;
  localparam int AF = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  param_fifo_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus ();

  param_fifo #(.WIDTH(W), .DEPTH_LOG2(DL), .AFULL_THRESH(AF)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents kept as a plain queue.
  logic [W-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit model_ok = 1'b0;

  always @(posedge clk) begin
    bit pop_ok, push_ok;
    if (!rstn) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      pop_ok  = bus.pop && (q.size() != 0);
      push_ok = bus.push && ((q.size() < D) || pop_ok);
      if (bus.push && !push_ok) m_ovf = 1'b1;
      if (bus.pop && q.size() == 0) m_unf = 1'b1;
      if (bus.clear) q.delete();
      else begin
        if (pop_ok)  void'(q.pop_front());
        if (push_ok) q.push_back(bus.indata);
      end
    end
    model_ok = 1'b1;
  end

  // Compare process: every cycle, after the outputs have settled.
  always @(negedge clk) begin
    if (model_ok) begin
      check("count", 32'(bus.count), 32'(q.size()));
      check("empty", 32'(bus.empty), 32'(q.size() == 0));
      check("full", 32'(bus.full), 32'(q.size() == D));
      check("almost_full", 32'(bus.almost_full), 32'(q.size() >= AF));
      if (q.size() != 0) check("outdata", 32'(bus.outdata), 32'(q[0]));
`ifdef FIFO_ERR_EN
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("underflow", 32'(bus.underflow), 32'(m_unf));
`endif
    end
  end

  // One clock cycle of stimulus. The inputs change #1 after the edge.
  task automatic cyc(input logic r, input logic c, input logic ps,
                     input logic pp, input logic [W-1:0] d);
    rstn       = r;
    bus.clear  = c;
    bus.push   = ps;
    bus.pop    = pp;
    bus.indata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [W-1:0] d); cyc(1, 0, 1, 0, d); endtask
  task automatic pop1();                        cyc(1, 0, 0, 1, 8'h00); endtask
  task automatic idle();                        cyc(1, 0, 0, 0, 8'h00); endtask

  initial begin
    bus.clear  = 1'b0;
    bus.push   = 1'b0;
    bus.pop    = 1'b0;
    bus.indata = '0;
    #1;
    cyc(0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    // Reset state.
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_af", 32'(bus.almost_full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
`ifdef FIFO_ERR_EN
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_unf", 32'(bus.underflow), 32'd0);
`endif
    idle();

    // Basic first-word-fall-through.
    push1(8'h11);
    push1(8'h22);
    check("b_count2", 32'(bus.count), 32'd2);
    check("b_out11", 32'(bus.outdata), 32'h11);
    pop1();
    check("b_out22", 32'(bus.outdata), 32'h22);
    check("b_count1", 32'(bus.count), 32'd1);
    pop1();
    check("b_empty", 32'(bus.empty), 32'd1);

    // Fill up, then push once more while full, then drain.
    push1(8'hA0);
    push1(8'hA1);
    check("f_af_2", 32'(bus.almost_full), 32'd0);
    push1(8'hA2);
    check("f_af_3", 32'(bus.almost_full), 32'd1);
    check("f_full_3", 32'(bus.full), 32'd0);
    push1(8'hA3);
    check("f_full_4", 32'(bus.full), 32'd1);
    push1(8'hFF);
    check("f_cnt_ovf", 32'(bus.count), 32'd4);
    check("f_out_ovf", 32'(bus.outdata), 32'hA0);
`ifdef FIFO_ERR_EN
    check("f_ovf", 32'(bus.overflow), 32'd1);
`endif
    for (int i = 0; i < 4; i++) begin
      check("f_drain", 32'(bus.outdata), 32'hA0 + 32'(i));
      pop1();
    end
    check("f_empty", 32'(bus.empty), 32'd1);

    // Push and pop together while full.
    for (int i = 0; i < 4; i++) push1(8'hA0 + 8'(i));
    cyc(1, 0, 1, 1, 8'h55);
    check("fp_count", 32'(bus.count), 32'd4);
    check("fp_out", 32'(bus.outdata), 32'hA1);
    for (int i = 0; i < 3; i++) pop1();
    check("fp_last", 32'(bus.outdata), 32'h55);
    pop1();

    // Push and pop together while empty: only the push takes effect.
    cyc(1, 0, 1, 1, 8'h77);
    check("ep_count", 32'(bus.count), 32'd1);
    check("ep_out", 32'(bus.outdata), 32'h77);
`ifdef FIFO_ERR_EN
    check("ep_unf", 32'(bus.underflow), 32'd1);
`endif
    pop1();

    // Single-word rounds that wrap the pointers.
    for (int i = 0; i < 10; i++) begin
      push1(8'(i));
      check("w_out", 32'(bus.outdata), 32'(i));
      pop1();
      check("w_empty", 32'(bus.empty), 32'd1);
    end

    // Clear overrides push, and reset overrides push.
    push1(8'h01);
    push1(8'h02);
    push1(8'h03);
    check("c_count3", 32'(bus.count), 32'd3);
    cyc(1, 1, 1, 0, 8'h04);
    check("c_count0", 32'(bus.count), 32'd0);
    check("c_empty", 32'(bus.empty), 32'd1);
    push1(8'h05);
    cyc(0, 0, 1, 0, 8'h06);
    check("r_count0", 32'(bus.count), 32'd0);
`ifdef FIFO_ERR_EN
    check("r_ovf0", 32'(bus.overflow), 32'd0);
`endif
    idle();

    // Random phases: push-heavy, pop-heavy, then balanced.
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        int pw, pr;
        logic r, c;
        pw = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
        pr = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
        r  = ($urandom_range(0, 199) != 0);
        c  = ($urandom_range(0, 49) == 0);
        cyc(r, c, $urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
            8'($urandom));
      end
    end

    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
